mc_sequencer: RTL and testbench

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_sequencer_if.sv | 30 +++
 rtl/mc_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mc_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mc_sequencer_if.sv
// Control bundle between the multicycle sequencer and the datapath it steers.
// master = sequencer side, slave = datapath side.
interface mc_sequencer_if;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite;
   logic        AdrSrc;
   logic        MemWrite;
   logic        IRWrite;
   logic        RegWrite;
   logic [1:0]  ResultSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ALUControl;
   logic [1:0]  ImmSrc;
   logic [1:0]  RegSrc;
   logic [3:0]  State;

   modport master (
      input  Instr, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
   );

   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
   );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle ARM-subset control unit: Moore FSM sequencing one shared ALU and
// unified memory, with condition-code gating of every architectural write.
module mc_sequencer (
   input  logic           clk,
   input  logic           reset,
   mc_sequencer_if.master bus
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB = 4'd4,
      MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
   } state_t;

   state_t     state, state_next;
   logic [3:0] flags;      // {N,Z,C,V}
   logic       condexr;

   logic [3:0] cond, rd;
   logic [1:0] op;
   logic [5:0] funct;
   assign cond  = bus.Instr[19:16];
   assign op    = bus.Instr[15:14];
   assign funct = bus.Instr[13:8];
   assign rd    = bus.Instr[3:0];
   wire unused_rn = &{1'b0, bus.Instr[7:4]};

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'b0000: return z;
         4'b0001: return !z;
         4'b0010: return cy;
         4'b0011: return !cy;
         4'b0100: return n;
         4'b0101: return !n;
         4'b0110: return v;
         4'b0111: return !v;
         4'b1000: return cy && !z;
         4'b1001: return !cy || z;
         4'b1010: return n == v;
         4'b1011: return n != v;
         4'b1100: return !z && (n == v);
         4'b1101: return z || (n != v);
         4'b1110: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // ALU command decode; unknown commands act as NOP (no register or flag write)
   logic [1:0] alu_op;
   logic       alu_valid, alu_nowrite, alu_cv;
   always_comb begin
      alu_op      = 2'b00;
      alu_valid   = 1'b1;
      alu_nowrite = 1'b0;
      alu_cv      = 1'b0;
      case (funct[4:1])
         4'b0100: alu_cv = 1'b1;
         4'b0010: begin alu_op = 2'b01; alu_cv = 1'b1; end
         4'b0000: alu_op = 2'b10;
         4'b1100: alu_op = 2'b11;
         4'b1010: begin alu_op = 2'b01; alu_cv = 1'b1; alu_nowrite = 1'b1; end
         4'b1000: begin alu_op = 2'b10; alu_nowrite = 1'b1; end
         default: begin alu_valid = 1'b0; alu_nowrite = 1'b1; end
      endcase
   end

   logic nowrite;
   assign nowrite = (op == 2'b00) && alu_nowrite;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   logic exec;
   assign exec = (state == EXECR) || (state == EXECI);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags   <= 4'b0000;
         condexr <= 1'b0;
      end else begin
         if (state == DECODE) condexr <= cond_ok(cond, flags);
         if (exec && funct[0] && condexr && alu_valid) begin
            flags[3:2] <= bus.ALUFlags[3:2];
            if (alu_cv) flags[1:0] <= bus.ALUFlags[1:0];
         end
      end
   end

   logic       adrsrc, irwrite, alusrca, regw, memw, branch, fetch;
   logic [1:0] alusrcb, resultsrc;

   // NOTE: every output of this block gets a default first, so no path through
   // the case can leave a variable unassigned and infer a latch.
   always_comb begin
      state_next = FETCH;
      adrsrc     = 1'b0;
      irwrite    = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      resultsrc  = 2'b00;
      regw       = 1'b0;
      memw       = 1'b0;
      branch     = 1'b0;
      fetch      = 1'b0;
      case (state)
         FETCH: begin
            state_next = DECODE;
            irwrite = 1'b1; alusrca = 1'b1; alusrcb = 2'b10; resultsrc = 2'b10; fetch = 1'b1;
         end
         DECODE: begin
            alusrca = 1'b1; alusrcb = 2'b10; resultsrc = 2'b10;
            case (op)
               2'b00:   state_next = funct[5] ? EXECI : EXECR;
               2'b01:   state_next = MEMADR;
               2'b10:   state_next = BRANCH;
               default: state_next = FETCH;
            endcase
         end
         MEMADR: begin
            state_next = funct[0] ? MEMRD : MEMWR;
            alusrcb = 2'b01;
         end
         MEMRD:  begin state_next = MEMWB; adrsrc = 1'b1; end
         MEMWB:  begin resultsrc = 2'b01; regw = 1'b1; end
         MEMWR:  begin adrsrc = 1'b1; memw = 1'b1; end
         EXECR:  state_next = ALUWB;
         EXECI:  begin state_next = ALUWB; alusrcb = 2'b01; end
         ALUWB:  regw = 1'b1;
         BRANCH: begin alusrcb = 2'b01; resultsrc = 2'b10; branch = 1'b1; end
         default: state_next = FETCH;
      endcase
   end

   // Write enables are held low while reset is asserted, independent of state
   assign bus.PCWrite    = !reset && (fetch ||
                           (condexr && (branch || (regw && !nowrite && rd == 4'hF))));
   assign bus.RegWrite   = !reset && regw && condexr && !nowrite;
   assign bus.MemWrite   = !reset && memw && condexr;
   assign bus.IRWrite    = !reset && irwrite;
   assign bus.AdrSrc     = adrsrc;
   assign bus.ResultSrc  = resultsrc;
   assign bus.ALUSrcA    = alusrca;
   assign bus.ALUSrcB    = alusrcb;
   assign bus.ALUControl = exec ? alu_op : 2'b00;
   assign bus.State      = state;

   always_comb begin
      bus.ImmSrc = 2'b00;
      bus.RegSrc = 2'b00;
      case (op)
         2'b01:   begin bus.ImmSrc = 2'b01; bus.RegSrc = funct[0] ? 2'b00 : 2'b10; end
         2'b10:   begin bus.ImmSrc = 2'b10; bus.RegSrc = 2'b01; end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed instructions followed by
// random instructions, compared against a table-driven instruction model.
module tb_mc_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   mc_sequencer_if bus ();
   mc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Per-state control settings as listed for each FSM state
   typedef struct packed {
      logic adr, irw, srca;
      logic [1:0] srcb, res;
      logic regw, memw, br;
   } ctl_t;
   ctl_t ctl [10];

   typedef struct packed {
      logic [1:0] aluctl;
      logic       wr, cv, ok;
   } alu_t;

   logic [3:0] m_flags;
   logic       m_condex;

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic alu_t alu_model(input logic [3:0] cmd);
      case (cmd)
         4'b0100: return '{aluctl: 2'b00, wr: 1'b1, cv: 1'b1, ok: 1'b1}; // ADD
         4'b0010: return '{aluctl: 2'b01, wr: 1'b1, cv: 1'b1, ok: 1'b1}; // SUB
         4'b0000: return '{aluctl: 2'b10, wr: 1'b1, cv: 1'b0, ok: 1'b1}; // AND
         4'b1100: return '{aluctl: 2'b11, wr: 1'b1, cv: 1'b0, ok: 1'b1}; // ORR
         4'b1010: return '{aluctl: 2'b01, wr: 1'b0, cv: 1'b1, ok: 1'b1}; // CMP
         4'b1000: return '{aluctl: 2'b10, wr: 1'b0, cv: 1'b0, ok: 1'b1}; // TST
         default: return '{aluctl: 2'b00, wr: 1'b0, cv: 1'b0, ok: 1'b0}; // NOP
      endcase
   endfunction

   function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      if (c == 4'hE) return 1'b1;
      if (c == 4'hF) return 1'b0;
      case (c[3:1])
         3'd0: return c[0] ^ z;
         3'd1: return c[0] ^ cy;
         3'd2: return c[0] ^ n;
         3'd3: return c[0] ^ v;
         3'd4: return c[0] ^ (cy && !z);
         3'd5: return c[0] ^ (n == v);
         default: return c[0] ^ (!z && (n == v));
      endcase
   endfunction

   function automatic logic [19:0] expect_vec(input int s, input logic [19:0] ins);
      ctl_t       r;
      alu_t       a;
      logic [1:0] op, imm, rsrc, aluctl;
      logic       lbit, writes, rw, pcw, mw;
      r    = ctl[s];
      op   = ins[15:14];
      lbit = ins[8];
      a    = alu_model(ins[12:9]);
      writes = (op == 2'b00) ? a.wr : 1'b1;
      rw   = r.regw && m_condex && writes;
      mw   = r.memw && m_condex;
      pcw  = (s == 0) || (m_condex && r.br) || (rw && ins[3:0] == 4'hF);
      aluctl = (s == 6 || s == 7) ? a.aluctl : 2'b00;
      imm  = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
      rsrc = (op == 2'b10) ? 2'b01 : (op == 2'b01 && !lbit) ? 2'b10 : 2'b00;
      return {s[3:0], pcw, r.adr, mw, r.irw, rw, r.res, r.srca, r.srcb, aluctl, imm, rsrc};
   endfunction

   function automatic logic [19:0] observed();
      return {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
              bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc};
   endfunction

   // Runs one instruction from FETCH; abort_at >= 0 asserts reset in that step.
   task automatic run_instr(input string tag, input logic [19:0] ins, input logic [3:0] fl,
                            input bit rand_fl, input int abort_at);
      int   seq[$];
      alu_t a;
      logic [3:0] applied;
      a = alu_model(ins[12:9]);
      seq = '{0, 1};
      case (ins[15:14])
         2'b00: seq = {seq, ins[13] ? 7 : 6, 8};
         2'b01: seq = ins[8] ? {seq, 2, 3, 4} : {seq, 2, 5};
         2'b10: seq = {seq, 9};
         default: ;
      endcase
      bus.Instr = ins;
      foreach (seq[k]) begin
         applied = rand_fl ? 4'($urandom) : fl;
         bus.ALUFlags = applied;
         @(negedge clk);
         check($sformatf("%s_step%0d", tag, k), observed(), expect_vec(seq[k], ins));
         if (k == abort_at) begin
            reset = 1'b1;
            #1;
            check({tag, "_abort"}, {12'd0, bus.State, bus.PCWrite, bus.IRWrite,
                  bus.RegWrite, bus.MemWrite}, 20'd0);
            m_flags = 4'b0000;
            m_condex = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            return;
         end
         if (seq[k] == 1) m_condex = passes(ins[19:16], m_flags);
         if ((seq[k] == 6 || seq[k] == 7) && ins[8] && m_condex && a.ok) begin
            m_flags[3:2] = applied[3:2];
            if (a.cv) m_flags[1:0] = applied[1:0];
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      ctl[0] = '{adr:1'b0, irw:1'b1, srca:1'b1, srcb:2'b10, res:2'b10, regw:1'b0, memw:1'b0, br:1'b0};
      ctl[1] = '{adr:1'b0, irw:1'b0, srca:1'b1, srcb:2'b10, res:2'b10, regw:1'b0, memw:1'b0, br:1'b0};
      ctl[2] = '{adr:1'b0, irw:1'b0, srca:1'b0, srcb:2'b01, res:2'b00, regw:1'b0, memw:1'b0, br:1'b0};
      ctl[3] = '{adr:1'b1, irw:1'b0, srca:1'b0, srcb:2'b00, res:2'b00, regw:1'b0, memw:1'b0, br:1'b0};
      ctl[4] = '{adr:1'b0, irw:1'b0, srca:1'b0, srcb:2'b00, res:2'b01, regw:1'b1, memw:1'b0, br:1'b0};
      ctl[5] = '{adr:1'b1, irw:1'b0, srca:1'b0, srcb:2'b00, res:2'b00, regw:1'b0, memw:1'b1, br:1'b0};
      ctl[6] = '{adr:1'b0, irw:1'b0, srca:1'b0, srcb:2'b00, res:2'b00, regw:1'b0, memw:1'b0, br:1'b0};
      ctl[7] = '{adr:1'b0, irw:1'b0, srca:1'b0, srcb:2'b01, res:2'b00, regw:1'b0, memw:1'b0, br:1'b0};
      ctl[8] = '{adr:1'b0, irw:1'b0, srca:1'b0, srcb:2'b00, res:2'b00, regw:1'b1, memw:1'b0, br:1'b0};
      ctl[9] = '{adr:1'b0, irw:1'b0, srca:1'b0, srcb:2'b01, res:2'b10, regw:1'b0, memw:1'b0, br:1'b1};

      bus.Instr    = 20'h0;
      bus.ALUFlags = 4'h0;
      m_flags      = 4'b0000;
      m_condex     = 1'b0;
      reset        = 1'b1;
      @(negedge clk);
      check("reset_hold", {12'd0, bus.State, bus.PCWrite, bus.IRWrite, bus.RegWrite,
            bus.MemWrite}, 20'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      run_instr("add_imm", 20'hE2802, 4'b0000, 1'b0, -1);
      run_instr("b_al",    20'hEA000, 4'b0000, 1'b0, -1);
      run_instr("beq_nz",  20'h0A000, 4'b0000, 1'b0, -1);
      run_instr("ldr",     20'hE5912, 4'b1111, 1'b0, -1);
      run_instr("str",     20'hE5812, 4'b1111, 1'b0, -1);
      run_instr("subs",    20'hE0511, 4'b0110, 1'b0, -1);
      check("subs_flags", {16'd0, m_flags}, 20'h00006);
      run_instr("addeq",   20'h02802, 4'b1111, 1'b0, -1);
      run_instr("addne",   20'h12802, 4'b1111, 1'b0, -1);
      run_instr("cmp_imm", 20'hE3500, 4'b1001, 1'b0, -1);
      run_instr("beq_cmp", 20'h0A000, 4'b0000, 1'b0, -1);
      run_instr("op11",    20'hEC000, 4'b1111, 1'b0, -1);
      run_instr("add_pc",  20'hE280F, 4'b0000, 1'b0, -1);

      repeat (150) begin
         logic [19:0] ins;
         ins = 20'($urandom);
         if ($urandom_range(1, 0) == 1) ins[19:16] = 4'hE;
         if ($urandom_range(3, 0) == 0) ins[3:0] = 4'hF;
         run_instr("rand", ins, 4'b0000, 1'b1, -1);
      end

      run_instr("subs_z", 20'hE0511, 4'b0110, 1'b0, -1);
      run_instr("str_abort", 20'hE5812, 4'b0000, 1'b0, 3);
      run_instr("beq_after_rst", 20'h0A000, 4'b0000, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
